// File: rtl/dpi_call_pkg.sv
//==============================================================================
// Module     : dpi_call_pkg
// Description: Shared types and constants for the DPI call arbiter.
//              - state_t    : arbiter FSM encoding (IDLE/ISSUE/WAIT/RETURN)
//              - DATA_W_DEF : default request payload width
//              - RES_W_DEF  : default call result width
//              - id_w(n)    : index width for n requesters, never below 1
// Revision   : 1.0 - initial release
//==============================================================================
`default_nettype none

package dpi_call_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RETURN = 2'd3
   } state_t;

   localparam int DATA_W_DEF = 32;
   localparam int RES_W_DEF  = 32;

   // $clog2(1) is 0; an index port still needs at least one bit.
   function automatic int id_w(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/dpi_call_arbiter_rr.sv
//==============================================================================
// Module     : rr_arbiter
// Description: Combinational round-robin pick. The search starts one position
//              after the last grant and wraps modulo NUM_REQ.
// Ports      : i_req   [NUM_REQ-1:0] request vector
//              i_last  [ID_W-1:0]    index of the previous grant
//              o_grant [NUM_REQ-1:0] one-hot winner (0 when no request)
//              o_idx   [ID_W-1:0]    winner index (0 when no request)
//              o_any                 at least one request asserted
// Revision   : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_arbiter
   import dpi_call_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = id_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_last,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [ID_W-1:0]    o_idx,
   output logic               o_any
);

   // One extra bit so last+offset (at most 2*NUM_REQ-1) cannot overflow
   // before the modulo fold.
   localparam int CW = ID_W + 1;

   logic [CW-1:0] w_cand;
   logic          w_found;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_cand  = '0;
      // Offset NUM_REQ lands back on i_last itself, so it has lowest priority.
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand = {1'b0, i_last} + CW'(k);
         if (w_cand >= CW'(NUM_REQ)) begin
            w_cand = w_cand - CW'(NUM_REQ);
         end
         if (!w_found && i_req[w_cand[ID_W-1:0]]) begin
            w_found                   = 1'b1;
            o_idx                     = w_cand[ID_W-1:0];
            o_grant[w_cand[ID_W-1:0]] = 1'b1;
         end
      end
   end

   assign o_any = w_found;

endmodule

`default_nettype wire

// File: rtl/dpi_call_arbiter.sv
//==============================================================================
// Module     : dpi_call_arbiter
// Description: Shares one DPI call channel among NUM_REQ requesters. The
//              arbiter grants requesters round-robin and issues one call at a
//              time. It waits for the stub's response and returns the result
//              to the granted requester. Only one call is outstanding.
// Options    : DPI_CALL_ARB_TIMEOUT_EN - when defined, WAIT is bounded by
//              TIMEOUT cycles and a timed-out call returns rsp_timeout=1 with
//              a zero result. When undefined, WAIT has no bound and
//              o_rsp_timeout is tied to 0.
// Ports      : clk, rst_n (async, active-low)
//              i_req_valid/i_req_data/o_req_ready : requester side
//              o_call_valid/i_call_ready/o_call_id/o_call_data : call issue
//              i_resp_valid/i_resp_result/i_resp_done : stub response
//              o_rsp_valid/o_rsp_result/o_rsp_done/o_rsp_timeout : result
//              o_busy : FSM not in IDLE
// Revision   : 1.0 - initial release
//==============================================================================
`default_nettype none

module dpi_call_arbiter
   import dpi_call_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int RES_W   = RES_W_DEF,
   parameter int TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        i_req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
   output logic [NUM_REQ-1:0]        o_req_ready,
   output logic                      o_call_valid,
   input  logic                      i_call_ready,
   output logic [id_w(NUM_REQ)-1:0]  o_call_id,
   output logic [DATA_W-1:0]         o_call_data,
   input  logic                      i_resp_valid,
   input  logic [RES_W-1:0]          i_resp_result,
   input  logic                      i_resp_done,
   output logic [NUM_REQ-1:0]        o_rsp_valid,
   output logic [RES_W-1:0]          o_rsp_result,
   output logic                      o_rsp_done,
   output logic                      o_rsp_timeout,
   output logic                      o_busy
);

   localparam int ID_W = id_w(NUM_REQ);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ID_W-1:0]     r_last;
   logic [ID_W-1:0]     r_id;
   logic [DATA_W-1:0]   r_data;
   logic [RES_W-1:0]    r_result;
   logic                r_done;

   logic [NUM_REQ-1:0]  w_grant;
   logic [ID_W-1:0]     w_idx;
   logic                w_any;
   logic [DATA_W-1:0]   w_sel_data;
   logic                w_timeout_hit;
   logic                w_accept;

   //---------------------------------------------------------------------------
   // Round-robin pick
   //---------------------------------------------------------------------------
   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .i_req   (i_req_valid),
      .i_last  (r_last),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   // Payload of the winner; the grant is one-hot so at most one slice matches.
   always_comb begin
      w_sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_sel_data = i_req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // req_ready is the grant itself, so any asserted request in IDLE completes
   // the handshake in that cycle.
   assign w_accept = (r_state == ST_IDLE) && w_any;

   //---------------------------------------------------------------------------
   // Optional WAIT-state timeout
   //---------------------------------------------------------------------------
`ifdef DPI_CALL_ARB_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT > 255) ? 16 : 8;

   logic [TO_W-1:0] r_cnt;
   logic [TO_W-1:0] w_cnt_inc;
   logic            r_timeout;

   assign w_cnt_inc = r_cnt + TO_W'(1);

   // Fires in the WAIT cycle whose increment reaches TIMEOUT. The first WAIT
   // cycle sees r_cnt=0, so RETURN follows the TIMEOUT-th WAIT cycle.
   assign w_timeout_hit = (r_state == ST_WAIT) && (w_cnt_inc == TO_W'(TIMEOUT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (r_state == ST_ISSUE) begin
         r_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
         r_cnt <= w_cnt_inc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timeout <= 1'b0;
      end else if (r_state == ST_WAIT) begin
         if (i_resp_valid) begin
            r_timeout <= 1'b0;
         end else if (w_timeout_hit) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign o_rsp_timeout = r_timeout;
`else
   assign w_timeout_hit = 1'b0;
   assign o_rsp_timeout = 1'b0;
`endif

   //---------------------------------------------------------------------------
   // FSM: state register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // FSM: next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // A response coinciding with call_ready is not looked at here.
            if (i_call_ready) begin
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (i_resp_valid || w_timeout_hit) begin
               w_state_nxt = ST_RETURN;
            end
         end
         ST_RETURN: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // FSM: outputs
   //---------------------------------------------------------------------------
   always_comb begin
      o_req_ready  = '0;
      o_call_valid = 1'b0;
      o_rsp_valid  = '0;
      o_busy       = (r_state != ST_IDLE);
      case (r_state)
         ST_IDLE:   o_req_ready      = w_grant;
         ST_ISSUE:  o_call_valid     = 1'b1;
         ST_RETURN: o_rsp_valid[r_id] = 1'b1;
         default:   ;
      endcase
   end

   //---------------------------------------------------------------------------
   // Datapath registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= ID_W'(NUM_REQ - 1);
         r_id   <= '0;
         r_data <= '0;
      end else if (w_accept) begin
         r_last <= w_idx;
         r_id   <= w_idx;
         r_data <= w_sel_data;
      end
   end

   // Result registers hold their value until the next RETURN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result <= '0;
         r_done   <= 1'b0;
      end else if (r_state == ST_WAIT) begin
         if (i_resp_valid) begin
            r_result <= i_resp_result;
            r_done   <= i_resp_done;
         end else if (w_timeout_hit) begin
            r_result <= '0;
            r_done   <= 1'b0;
         end
      end
   end

   assign o_call_id    = r_id;
   assign o_call_data  = r_data;
   assign o_rsp_result = r_result;
   assign o_rsp_done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_dpi_call_arbiter.sv
//==============================================================================
// Module     : tb_dpi_call_arbiter
// Description: Scoreboard bench for dpi_call_arbiter (NUM_REQ=4, 32-bit data,
//              TIMEOUT=10). Directed stimulus pushes expected calls and
//              results into queues. Independent monitors pop and compare on
//              every call handshake and every rsp_valid. The timeout scenario
//              runs only when DPI_CALL_ARB_TIMEOUT_EN is defined.
// Revision   : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dpi_call_arbiter;

   localparam int N = 4;

   typedef struct packed {
      logic [1:0]  id;
      logic [31:0] data;
   } call_t;

   typedef struct packed {
      logic [3:0]  oh;
      logic [31:0] res;
      logic        done;
      logic        to;
   } rsp_t;

   logic         clk;
   logic         rst_n;
   logic [3:0]   i_req_valid;
   logic [127:0] i_req_data;
   logic [3:0]   o_req_ready;
   logic         o_call_valid;
   logic         i_call_ready;
   logic [1:0]   o_call_id;
   logic [31:0]  o_call_data;
   logic         i_resp_valid;
   logic [31:0]  i_resp_result;
   logic         i_resp_done;
   logic [3:0]   o_rsp_valid;
   logic [31:0]  o_rsp_result;
   logic         o_rsp_done;
   logic         o_rsp_timeout;
   logic         o_busy;

   // Stub and stray-response sources, merged onto the response inputs.
   logic         ready_level;
   logic         stub_v, stub_dn;
   logic [31:0]  stub_res;
   logic         stray_v, stray_done;
   logic [31:0]  stray_res;
   logic         stub_en, stub_xor, stub_done;
   int           stub_delay;
   logic [31:0]  stub_result;

   assign i_call_ready  = ready_level;
   assign i_resp_valid  = stub_v | stray_v;
   assign i_resp_result = stray_v ? stray_res : stub_res;
   assign i_resp_done   = stray_v ? stray_done : stub_dn;

   call_t call_q[$];
   rsp_t  rsp_q[$];
   int    n_vec;
   int    n_miss;

   dpi_call_arbiter #(
      .NUM_REQ (N),
      .DATA_W  (32),
      .RES_W   (32),
      .TIMEOUT (10)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_req_valid   (i_req_valid),
      .i_req_data    (i_req_data),
      .o_req_ready   (o_req_ready),
      .o_call_valid  (o_call_valid),
      .i_call_ready  (i_call_ready),
      .o_call_id     (o_call_id),
      .o_call_data   (o_call_data),
      .i_resp_valid  (i_resp_valid),
      .i_resp_result (i_resp_result),
      .i_resp_done   (i_resp_done),
      .o_rsp_valid   (o_rsp_valid),
      .o_rsp_result  (o_rsp_result),
      .o_rsp_done    (o_rsp_done),
      .o_rsp_timeout (o_rsp_timeout),
      .o_busy        (o_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_call(input logic [1:0] id, input logic [31:0] d);
      call_q.push_back({id, d});
   endtask

   task automatic push_rsp(input logic [3:0] oh, input logic [31:0] res, input logic done,
                           input logic to);
      rsp_q.push_back({oh, res, done, to});
   endtask

   // Bounded wait for both scoreboards to empty; ends at posedge+1.
   task automatic wait_drain(input int budget);
      int c;
      c = 0;
      while ((call_q.size() != 0 || rsp_q.size() != 0) && c < budget) begin
         @(negedge clk);
         c++;
      end
      n_vec++;
      if (call_q.size() != 0 || rsp_q.size() != 0) begin
         n_miss++;
         $display("FAIL drain_timeout: got %0d calls %0d rsps pending expected 0",
                  call_q.size(), rsp_q.size());
         call_q.delete();
         rsp_q.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   //---------------------------------------------------------------------------
   // Call stub: answers each accepted call after stub_delay cycles
   //---------------------------------------------------------------------------
   initial begin : stub
      logic [31:0] cap;
      stub_v   = 1'b0;
      stub_res = '0;
      stub_dn  = 1'b0;
      forever begin
         @(negedge clk);
         if (stub_en && o_call_valid && i_call_ready) begin
            cap = o_call_data;
            repeat (stub_delay) @(posedge clk);
            #1;
            stub_v   = 1'b1;
            stub_res = stub_xor ? (cap ^ 32'hFFFF_0000) : stub_result;
            stub_dn  = stub_done;
            @(posedge clk);
            #1;
            stub_v = 1'b0;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Monitors
   //---------------------------------------------------------------------------
   initial begin : mon_call
      call_t e;
      forever begin
         @(negedge clk);
         if (o_call_valid && i_call_ready) begin
            n_vec++;
            if (call_q.size() == 0) begin
               n_miss++;
               $display("FAIL call_unexpected: got id %0d data %h expected none",
                        o_call_id, o_call_data);
            end else begin
               e = call_q.pop_front();
               if (o_call_id !== e.id || o_call_data !== e.data) begin
                  n_miss++;
                  $display("FAIL call: got id %0d data %h expected id %0d data %h",
                           o_call_id, o_call_data, e.id, e.data);
               end
            end
         end
      end
   end

   initial begin : mon_rsp
      rsp_t e;
      forever begin
         @(negedge clk);
         if (o_rsp_valid != 4'b0000) begin
            n_vec++;
            if (rsp_q.size() == 0) begin
               n_miss++;
               $display("FAIL rsp_unexpected: got valid %b result %h expected none",
                        o_rsp_valid, o_rsp_result);
            end else begin
               e = rsp_q.pop_front();
               if ({o_rsp_valid, o_rsp_result, o_rsp_done, o_rsp_timeout} !== e) begin
                  n_miss++;
                  $display("FAIL rsp: got valid %b res %h done %b to %b expected valid %b res %h done %b to %b",
                           o_rsp_valid, o_rsp_result, o_rsp_done, o_rsp_timeout,
                           e.oh, e.res, e.done, e.to);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   //---------------------------------------------------------------------------
   // Directed stimulus
   //---------------------------------------------------------------------------
   initial begin : main
      int g;
      int cyc;
      n_vec       = 0;
      n_miss      = 0;
      rst_n       = 1'b0;
      i_req_valid = '0;
      i_req_data  = '0;
      ready_level = 1'b1;
      stray_v     = 1'b0;
      stray_res   = '0;
      stray_done  = 1'b0;
      stub_en     = 1'b1;
      stub_xor    = 1'b0;
      stub_done   = 1'b0;
      stub_delay  = 1;
      stub_result = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy",       64'(o_busy),        64'd0);
      chk("rst_call_valid", 64'(o_call_valid),  64'd0);
      chk("rst_call_id",    64'(o_call_id),     64'd0);
      chk("rst_call_data",  64'(o_call_data),   64'd0);
      chk("rst_rsp_valid",  64'(o_rsp_valid),   64'd0);
      chk("rst_rsp_result", 64'(o_rsp_result),  64'd0);
      chk("rst_rsp_done",   64'(o_rsp_done),    64'd0);
      chk("rst_rsp_to",     64'(o_rsp_timeout), 64'd0);
      chk("rst_req_ready",  64'(o_req_ready),   64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single request on requester 2, response in the 2nd WAIT cycle
      stub_result = 32'h0000_1234;
      stub_done   = 1'b1;
      stub_delay  = 2;
      push_call(2'd2, 32'hDEAD_BEEF);
      push_rsp(4'b0100, 32'h0000_1234, 1'b1, 1'b0);
      i_req_valid = 4'b0100;
      i_req_data[2*32 +: 32] = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("single_req_ready", 64'(o_req_ready), 64'h4);
      @(posedge clk);
      #1 i_req_valid = '0;
      @(negedge clk);
      chk("single_busy", 64'(o_busy), 64'd1);
      chk("single_call_valid", 64'(o_call_valid), 64'd1);
      wait_drain(50);
      chk("single_hold_result", 64'(o_rsp_result), 64'h1234);
      chk("single_hold_done",   64'(o_rsp_done),   64'd1);

      // Stray response while IDLE, then requester 1
      stub_result = 32'h0000_5678;
      stub_done   = 1'b0;
      stub_delay  = 1;
      stray_v     = 1'b1;
      stray_res   = 32'hBADB_AD00;
      stray_done  = 1'b1;
      @(posedge clk);
      #1 stray_v = 1'b0;
      @(negedge clk);
      chk("stray_busy",   64'(o_busy),       64'd0);
      chk("stray_result", 64'(o_rsp_result), 64'h1234);
      push_call(2'd1, 32'h1111_0001);
      push_rsp(4'b0010, 32'h0000_5678, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      i_req_valid = 4'b0010;
      i_req_data[1*32 +: 32] = 32'h1111_0001;
      @(posedge clk);
      #1 i_req_valid = '0;
      wait_drain(50);

      // call_ready stalled for 5 cycles while another requester waits
      stub_result = 32'hCAFE_0003;
      stub_done   = 1'b1;
      ready_level = 1'b0;
      push_call(2'd3, 32'h3333_3333);
      push_rsp(4'b1000, 32'hCAFE_0003, 1'b1, 1'b0);
      i_req_valid = 4'b1000;
      i_req_data[3*32 +: 32] = 32'h3333_3333;
      @(posedge clk);
      #1 i_req_valid = 4'b0001;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         chk("stall_call_valid", 64'(o_call_valid), 64'd1);
         chk("stall_call_data",  64'(o_call_data),  64'h3333_3333);
         chk("stall_req_ready",  64'(o_req_ready),  64'd0);
         @(posedge clk);
         #1;
      end
      ready_level = 1'b1;
      i_req_valid = '0;
      wait_drain(50);

      // Reset pulsed during WAIT; the late response must be ignored
      stub_result = 32'hDEAD_0000;
      stub_delay  = 6;
      push_call(2'd2, 32'h2222_2222);
      i_req_valid = 4'b0100;
      i_req_data[2*32 +: 32] = 32'h2222_2222;
      @(posedge clk);
      #1 i_req_valid = '0;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("wait_busy", 64'(o_busy), 64'd1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_busy",       64'(o_busy),       64'd0);
      chk("midrst_call_valid", 64'(o_call_valid), 64'd0);
      chk("midrst_call_data",  64'(o_call_data),  64'd0);
      chk("midrst_rsp_result", 64'(o_rsp_result), 64'd0);
      chk("midrst_rsp_done",   64'(o_rsp_done),   64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("postrst_busy", 64'(o_busy), 64'd0);
      wait_drain(10);

      // All four requesters held for 8 grants: 0,1,2,3,0,1,2,3
      stub_xor   = 1'b1;
      stub_done  = 1'b1;
      stub_delay = 1;
      for (int r = 0; r < 2; r++) begin
         push_call(2'd0, 32'h0000_00A0); push_rsp(4'b0001, 32'hFFFF_00A0, 1'b1, 1'b0);
         push_call(2'd1, 32'h0000_00A1); push_rsp(4'b0010, 32'hFFFF_00A1, 1'b1, 1'b0);
         push_call(2'd2, 32'h0000_00A2); push_rsp(4'b0100, 32'hFFFF_00A2, 1'b1, 1'b0);
         push_call(2'd3, 32'h0000_00A3); push_rsp(4'b1000, 32'hFFFF_00A3, 1'b1, 1'b0);
      end
      i_req_data  = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
      i_req_valid = 4'b1111;
      g   = 0;
      cyc = 0;
      while (g < 8 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (o_req_ready != 4'b0000) begin
            if (g == 0) chk("rr_first_grant", 64'(o_req_ready), 64'h1);
            g++;
         end
      end
      @(posedge clk);
      #1 i_req_valid = '0;
      wait_drain(100);

`ifdef DPI_CALL_ARB_TIMEOUT_EN
      // Stub never answers: RETURN on the 11th cycle after entering WAIT
      stub_en = 1'b0;
      push_call(2'd1, 32'h1010_1010);
      push_rsp(4'b0010, 32'h0000_0000, 1'b0, 1'b1);
      i_req_valid = 4'b0010;
      i_req_data[1*32 +: 32] = 32'h1010_1010;
      @(posedge clk);
      #1 i_req_valid = '0;
      @(posedge clk);
      g = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (o_rsp_valid != 4'b0000 && g == 0) g = k;
      end
      chk("timeout_cycle", 64'(g), 64'd11);
      @(posedge clk);
      #1;
      stray_v    = 1'b1;
      stray_res  = 32'h7777_7777;
      stray_done = 1'b1;
      @(posedge clk);
      #1 stray_v = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("timeout_hold_flag", 64'(o_rsp_timeout), 64'd1);
      chk("timeout_hold_res",  64'(o_rsp_result),  64'd0);
      stub_en = 1'b1;
      wait_drain(10);
`else
      chk("no_timeout_flag", 64'(o_rsp_timeout), 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

`default_nettype wire
